// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer compare/interrupt block: default counter
// width, register word indices on the MMIO bus and CTRL/STATUS bit positions.
// ----------------------------------------------------------------------------
package timer_pkg;

   localparam int TMR_CNT_W = 32;

   // Register word indices (addr[2:0]); 5-7 are reserved.
   localparam logic [2:0] ADDR_COUNT  = 3'd0;
   localparam logic [2:0] ADDR_CMP    = 3'd1;
   localparam logic [2:0] ADDR_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_CTRL   = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   // CTRL bit positions
   localparam int CTRL_EN     = 0;
   localparam int CTRL_PERIOD = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bit positions
   localparam int ST_PEND = 0;
   localparam int ST_OVR  = 1;

endpackage : timer_pkg

// File: rtl/timer_compare_irq_if.sv
// ----------------------------------------------------------------------------
// timer_compare_irq_if
// MMIO bus between the GPIO-side bus master and the timer compare block.
//   sel   : access strobe, one cycle per access
//   we    : 1 = write, 0 = read (qualified by sel)
//   addr  : register word index
//   wdata : write data
//   rdata : registered read data
// ----------------------------------------------------------------------------
interface timer_compare_irq_if
   import timer_pkg::*;
#(
   parameter int CNT_W = TMR_CNT_W
);
   logic             sel;
   logic             we;
   logic [2:0]       addr;
   logic [CNT_W-1:0] wdata;
   logic [CNT_W-1:0] rdata;

   modport master (
      output sel,
      output we,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  sel,
      input  we,
      input  addr,
      input  wdata,
      output rdata
   );
endinterface : timer_compare_irq_if

// File: rtl/timer_cmp_ge.sv
// ----------------------------------------------------------------------------
// timer_cmp_ge
// Wrap-safe "a >= b" for free-running counters: true when (a - b) mod 2^W
// has a clear MSB, i.e. a is at or ahead of b by less than half the range.
//   i_a  : running count
//   i_b  : compare value
//   o_ge : 1 when i_a is at or past i_b (modular)
// ----------------------------------------------------------------------------
module timer_cmp_ge #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_ge
);
   logic [W-1:0] w_diff;

   assign w_diff = i_a - i_b;
   assign o_ge   = ~w_diff[W-1];
endmodule : timer_cmp_ge

// File: rtl/timer_compare_irq.sv
// ----------------------------------------------------------------------------
// timer_compare_irq
// Compare/interrupt unit on the free-running CPU timer count. Holds CMP,
// PERIOD, CTRL and STATUS registers, raises a level interrupt when the count
// reaches CMP and optionally auto-reloads CMP by PERIOD.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   counter_in : running count from the CPU timer (wraps modulo 2^CNT_W)
//   bus        : MMIO slave port (sel/we/addr/wdata in, registered rdata out)
//   irq        : registered level interrupt
// ----------------------------------------------------------------------------
module timer_compare_irq
   import timer_pkg::*;
#(
   parameter int               CNT_W   = TMR_CNT_W,
   parameter logic [CNT_W-1:0] RST_CMP = {CNT_W{1'b1}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CNT_W-1:0]   counter_in,
   timer_compare_irq_if.slave bus,
   output logic               irq
);

   logic [CNT_W-1:0] r_cmp;
   logic [CNT_W-1:0] r_period;
   logic             r_en;
   logic             r_periodic;
   logic             r_irq_en;
   logic             r_pend;
   logic             r_ovr;
   logic [CNT_W-1:0] r_rdata;
   logic             r_irq;

   logic [CNT_W-1:0] w_cmp_nxt;
   logic [CNT_W-1:0] w_period_nxt;
   logic             w_en_nxt;
   logic             w_periodic_nxt;
   logic             w_irq_en_nxt;
   logic             w_pend_nxt;
   logic             w_ovr_nxt;
   logic [CNT_W-1:0] w_rdata_nxt;
   logic             w_irq_nxt;
   logic             w_ge;
   logic             w_match;
   logic             w_wr;
   logic             w_rd;

   timer_cmp_ge #(.W(CNT_W)) u_cmp_ge (
      .i_a  (counter_in),
      .i_b  (r_cmp),
      .o_ge (w_ge)
   );

   assign w_match = r_en & w_ge;
   assign w_wr    = bus.sel & bus.we;
   assign w_rd    = bus.sel & ~bus.we;

   // Next-state for the register file: W1C, then match/reload, then bus writes
   // (the bus write wins for CMP/CTRL; a match set wins over a PEND clear).
   always_comb begin
      w_cmp_nxt      = r_cmp;
      w_period_nxt   = r_period;
      w_en_nxt       = r_en;
      w_periodic_nxt = r_periodic;
      w_irq_en_nxt   = r_irq_en;
      w_pend_nxt     = r_pend;
      w_ovr_nxt      = r_ovr;

      if (w_wr && (bus.addr == ADDR_STATUS)) begin
         w_pend_nxt = r_pend & ~bus.wdata[ST_PEND];
         w_ovr_nxt  = r_ovr  & ~bus.wdata[ST_OVR];
      end else begin
         w_pend_nxt = r_pend;
         w_ovr_nxt  = r_ovr;
      end

      if (w_match) begin
         w_pend_nxt = 1'b1;
         // Overrun is judged on the PEND value before this edge's W1C.
         if (r_pend) begin
            w_ovr_nxt = 1'b1;
         end else begin
            w_ovr_nxt = w_ovr_nxt;
         end
         if (r_periodic && (r_period != {CNT_W{1'b0}})) begin
            w_cmp_nxt = r_cmp + r_period;
         end else begin
            w_en_nxt = 1'b0;
         end
      end else begin
         w_pend_nxt = w_pend_nxt;
      end

      if (w_wr) begin
         case (bus.addr)
            ADDR_CMP:    w_cmp_nxt    = bus.wdata;
            ADDR_PERIOD: w_period_nxt = bus.wdata;
            ADDR_CTRL: begin
               w_en_nxt       = bus.wdata[CTRL_EN];
               w_periodic_nxt = bus.wdata[CTRL_PERIOD];
               w_irq_en_nxt   = bus.wdata[CTRL_IRQ_EN];
            end
            default:     w_cmp_nxt    = w_cmp_nxt;
         endcase
      end else begin
         w_cmp_nxt = w_cmp_nxt;
      end

      w_irq_nxt = w_pend_nxt & w_irq_en_nxt;
   end

   // Read mux: registers return their pre-edge values; rdata holds between reads.
   always_comb begin
      w_rdata_nxt = r_rdata;
      if (w_rd) begin
         case (bus.addr)
            ADDR_COUNT:  w_rdata_nxt = counter_in;
            ADDR_CMP:    w_rdata_nxt = r_cmp;
            ADDR_PERIOD: w_rdata_nxt = r_period;
            ADDR_CTRL:   w_rdata_nxt = {{(CNT_W-3){1'b0}}, r_irq_en, r_periodic, r_en};
            ADDR_STATUS: w_rdata_nxt = {{(CNT_W-2){1'b0}}, r_ovr, r_pend};
            default:     w_rdata_nxt = {CNT_W{1'b0}};
         endcase
      end else begin
         w_rdata_nxt = r_rdata;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmp      <= RST_CMP;
         r_period   <= {CNT_W{1'b0}};
         r_en       <= 1'b0;
         r_periodic <= 1'b0;
         r_irq_en   <= 1'b0;
         r_pend     <= 1'b0;
         r_ovr      <= 1'b0;
         r_rdata    <= {CNT_W{1'b0}};
         r_irq      <= 1'b0;
      end else begin
         r_cmp      <= w_cmp_nxt;
         r_period   <= w_period_nxt;
         r_en       <= w_en_nxt;
         r_periodic <= w_periodic_nxt;
         r_irq_en   <= w_irq_en_nxt;
         r_pend     <= w_pend_nxt;
         r_ovr      <= w_ovr_nxt;
         r_rdata    <= w_rdata_nxt;
         r_irq      <= w_irq_nxt;
      end
   end

   assign bus.rdata = r_rdata;
   assign irq       = r_irq;

endmodule : timer_compare_irq

// File: tb/tb_timer_compare_irq.sv
// ----------------------------------------------------------------------------
// tb_timer_compare_irq
// Self-checking bench for timer_compare_irq. Reads push their expected value
// into a scoreboard queue; the value is popped and compared once rdata is due.
// ----------------------------------------------------------------------------
module tb_timer_compare_irq;
   import timer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] counter_in;
   logic        irq;

   timer_compare_irq_if #(.CNT_W(32)) bus_if ();

   timer_compare_irq #(.CNT_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .counter_in (counter_in),
      .bus        (bus_if.slave),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   string       q_tag[$];
   logic [31:0] q_exp[$];
   bit          rd_pending = 1'b0;

   // Single comparison point: counts and reports mismatches.
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one edge, sample #1 later, retire a pending read from the scoreboard.
   task automatic tick();
      string       t;
      logic [31:0] e;
      @(posedge clk);
      #1;
      if (rd_pending) begin
         if (q_exp.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
         end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            check_eq(t, bus_if.rdata, e);
         end
      end
      rd_pending = 1'b0;
      bus_if.sel = 1'b0;
      bus_if.we  = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus_if.sel   = 1'b1;
      bus_if.we    = 1'b1;
      bus_if.addr  = a;
      bus_if.wdata = d;
      tick();
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
      bus_if.sel  = 1'b1;
      bus_if.we   = 1'b0;
      bus_if.addr = a;
      q_tag.push_back(tag);
      q_exp.push_back(exp);
      rd_pending = 1'b1;
      tick();
   endtask

   task automatic chk_irq(input logic exp, input string tag);
      check_eq(tag, {31'd0, irq}, {31'd0, exp});
   endtask

   logic [31:0] wrap_v [6];

   initial begin
      reset        = 1'b0;
      counter_in   = 32'd0;
      bus_if.sel   = 1'b0;
      bus_if.we    = 1'b0;
      bus_if.addr  = 3'd0;
      bus_if.wdata = 32'd0;

      // Reset state
      tick(); tick();
      chk_irq(1'b0, "rst_irq");
      check_eq("rst_rdata", bus_if.rdata, 32'd0);
      reset = 1'b1;
      rd(ADDR_CMP,    32'hFFFF_FFFF, "rst_cmp");
      rd(ADDR_CTRL,   32'd0,         "rst_ctrl");
      rd(ADDR_STATUS, 32'd0,         "rst_status");
      rd(ADDR_PERIOD, 32'd0,         "rst_period");

      // One-shot
      wr(ADDR_CMP, 32'd100);
      wr(ADDR_CTRL, 32'd5);
      for (int v = 98; v <= 102; v++) begin
         counter_in = v;
         tick();
         chk_irq((v >= 100) ? 1'b1 : 1'b0, "oneshot_irq");
      end
      rd(ADDR_CTRL,   32'd4, "oneshot_ctrl_en_clr");
      rd(ADDR_STATUS, 32'd1, "oneshot_status");
      wr(ADDR_STATUS, 32'd3);
      chk_irq(1'b0, "oneshot_irq_w1c");
      rd(ADDR_STATUS, 32'd0, "oneshot_status_clr");

      // Periodic
      counter_in = 32'd0;
      wr(ADDR_PERIOD, 32'd5);
      wr(ADDR_CMP, 32'd10);
      wr(ADDR_CTRL, 32'd7);
      for (int v = 8; v <= 12; v++) begin
         counter_in = v;
         tick();
         chk_irq((v >= 10) ? 1'b1 : 1'b0, "per_irq1");
      end
      rd(ADDR_CMP, 32'd15, "per_cmp15");
      counter_in = 32'd13;
      wr(ADDR_STATUS, 32'd1);
      chk_irq(1'b0, "per_irq_clr");
      for (int v = 14; v <= 16; v++) begin
         counter_in = v;
         tick();
         chk_irq((v >= 15) ? 1'b1 : 1'b0, "per_irq2");
      end
      for (int v = 17; v <= 20; v++) begin
         counter_in = v;
         tick();
         chk_irq(1'b1, "per_irq3");
      end
      rd(ADDR_STATUS, 32'd3,  "per_ovr");
      rd(ADDR_CMP,    32'd25, "per_cmp25");
      wr(ADDR_CTRL, 32'd0);
      wr(ADDR_STATUS, 32'd3);
      chk_irq(1'b0, "per_irq_off");

      // Wrap
      counter_in = 32'hFFFF_FFFE;
      wr(ADDR_CMP, 32'd2);
      wr(ADDR_CTRL, 32'd5);
      wrap_v = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3};
      for (int i = 0; i < 6; i++) begin
         counter_in = wrap_v[i];
         tick();
         chk_irq((i >= 4) ? 1'b1 : 1'b0, "wrap_irq");
      end
      wr(ADDR_STATUS, 32'd3);
      chk_irq(1'b0, "wrap_irq_clr");
      rd(ADDR_CTRL, 32'd4, "wrap_ctrl");
      wr(ADDR_PERIOD, 32'd4);
      counter_in = 32'hFFFF_FFF0;
      wr(ADDR_CMP, 32'hFFFF_FFFF);
      wr(ADDR_CTRL, 32'd7);
      counter_in = 32'hFFFF_FFFF;
      tick();
      counter_in = 32'd0;
      rd(ADDR_CMP, 32'd3, "wrap_reload");
      wr(ADDR_CTRL, 32'd0);
      wr(ADDR_STATUS, 32'd3);

      // Collision: W1C PEND on the match edge
      counter_in = 32'd40;
      wr(ADDR_CMP, 32'd50);
      wr(ADDR_CTRL, 32'd5);
      counter_in = 32'd50;
      wr(ADDR_STATUS, 32'd1);
      chk_irq(1'b1, "col_w1c_irq");
      rd(ADDR_STATUS, 32'd1, "col_w1c_pend");
      wr(ADDR_STATUS, 32'd3);

      // Collision: CMP write on a periodic match edge
      wr(ADDR_PERIOD, 32'd5);
      counter_in = 32'd90;
      wr(ADDR_CMP, 32'd100);
      wr(ADDR_CTRL, 32'd7);
      counter_in = 32'd100;
      wr(ADDR_CMP, 32'd500);
      rd(ADDR_CMP,  32'd500, "col_cmp_wins");
      rd(ADDR_CTRL, 32'd7,   "col_cmp_ctrl");

      // Collision: CTRL write on a one-shot match edge keeps EN
      wr(ADDR_CTRL, 32'd0);
      wr(ADDR_STATUS, 32'd3);
      wr(ADDR_CMP, 32'd600);
      wr(ADDR_CTRL, 32'd5);
      counter_in = 32'd600;
      wr(ADDR_CTRL, 32'd5);
      rd(ADDR_CTRL,   32'd5, "col_ctrl_wins");
      rd(ADDR_STATUS, 32'd3, "col_ctrl_rematch");
      rd(ADDR_CTRL,   32'd4, "col_ctrl_en_clr");
      wr(ADDR_CTRL, 32'd0);
      wr(ADDR_STATUS, 32'd3);
      chk_irq(1'b0, "col_irq_off");

      // Bus
      counter_in = 32'd1234;
      rd(ADDR_COUNT, 32'd1234, "bus_count");
      counter_in = 32'd1300;
      wr(ADDR_COUNT, 32'd77);
      check_eq("bus_rdata_hold", bus_if.rdata, 32'd1234);
      rd(3'd6, 32'd0, "bus_rsvd6");
      wr(3'd5, 32'hFFFF_FFFF);
      wr(3'd7, 32'hFFFF_FFFF);
      rd(ADDR_CMP,    32'd600, "bus_cmp_kept");
      rd(ADDR_PERIOD, 32'd5,   "bus_period_kept");
      rd(ADDR_CTRL,   32'd0,   "bus_ctrl_kept");
      rd(ADDR_STATUS, 32'd0,   "bus_status_kept");
      rd(3'd5,        32'd0,   "bus_rsvd5");

      // Asynchronous reset mid-run with PEND=1, irq=1
      counter_in = 32'd0;
      wr(ADDR_CMP, 32'd10);
      wr(ADDR_CTRL, 32'd5);
      counter_in = 32'd10;
      tick();
      chk_irq(1'b1, "mid_irq_set");
      rd(ADDR_PERIOD, 32'd5, "mid_period");
      #2;
      reset = 1'b0;
      #1;
      chk_irq(1'b0, "mid_rst_irq");
      check_eq("mid_rst_rdata", bus_if.rdata, 32'd0);
      tick();
      reset = 1'b1;
      rd(ADDR_CMP,    32'hFFFF_FFFF, "mid_rst_cmp");
      rd(ADDR_CTRL,   32'd0,         "mid_rst_ctrl");
      rd(ADDR_STATUS, 32'd0,         "mid_rst_status");
      rd(ADDR_PERIOD, 32'd0,         "mid_rst_period");
      chk_irq(1'b0, "mid_rst_irq_after");

      check_eq("sb_drained", q_exp.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Run-time bound.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_timer_compare_irq
